mealy_switch_toggle: RTL and testbench

- Mealy-type push-button toggle ("light switch") controller.
- Each press of `control` (0->1) flips the latched on/off state. `out` reports that state.
- `out` reacts combinationally in the same cycle a press or release is seen, so it leads the registered state by one cycle.
- Standalone leaf block driven directly by a synchronised button/switch level. Input synchronisation is the caller's job.

---
 rtl/mealy_switch_pkg.sv | 27 ++
 rtl/mealy_switch_toggle.sv | 56 +++++
 tb/tb_mealy_switch_toggle.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mealy_switch_pkg.sv
// Shared types and helpers for the Mealy push-button toggle controller.
package mealy_switch_pkg;

    // Light / button state encoding.
    typedef enum logic [1:0] {
        OFF_REL  = 2'b00,
        ON_HELD  = 2'b01,
        ON_REL   = 2'b10,
        OFF_HELD = 2'b11
    } state_t;

    // Mealy output equation: light state including the effect of the
    // current button level. Usable by both RTL and reference models.
    function automatic logic state_out(input state_t s, input logic c);
        logic v;
        v = 1'b0;
        case (s)
            OFF_REL:  v = c;
            ON_HELD:  v = 1'b1;
            ON_REL:   v = ~c;
            OFF_HELD: v = 1'b0;
            default:  v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mealy_switch_toggle.sv
// Push-button "light switch": each 0->1 press flips the latched light state.
// The output is Mealy, so it follows the button combinationally and leads the
// registered state by one cycle. A press held through reset release is not
// taken as a toggle until the button has been seen released once (armed).
module mealy_switch_toggle
    import mealy_switch_pkg::*;
#(
    parameter bit INIT_ON = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic control,
    output logic out
);

    localparam state_t RST_STATE = INIT_ON ? ON_REL : OFF_REL;

    state_t r_state;
    state_t w_next;
    logic   r_armed;

    // State and arming registers; armed sets at the first edge that sees release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= RST_STATE;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next;
            r_armed <= r_armed | ~control;
        end
    end

    // Next-state logic; presses only count once armed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            OFF_REL:  if (control && r_armed) w_next = ON_HELD;
            ON_HELD:  if (!control)           w_next = ON_REL;
            ON_REL:   if (control && r_armed) w_next = OFF_HELD;
            OFF_HELD: if (!control)           w_next = OFF_REL;
            default:                          w_next = RST_STATE;
        endcase
    end

    // Output logic; reset and the unarmed window force the initial light level.
    always_comb begin
        out = INIT_ON;
        if (reset && r_armed) begin
            case (r_state)
                OFF_REL, ON_HELD, ON_REL, OFF_HELD: out = state_out(r_state, control);
                default:                            out = INIT_ON;
            endcase
        end
    end

endmodule

// File: tb/tb_mealy_switch_toggle.sv
// Scoreboard bench for mealy_switch_toggle with INIT_ON=0 and INIT_ON=1 instances.
module tb_mealy_switch_toggle;

    logic clk;
    logic rst0, ctl0, out0;
    logic rst1, ctl1, out1;

    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_push = 0;
    int    n_pop  = 0;
    int    q_dut[$];
    logic  q_exp[$];
    string q_name[$];

    mealy_switch_toggle #(.INIT_ON(1'b0)) u_dut0 (
        .clock  (clk),
        .reset  (rst0),
        .control(ctl0),
        .out    (out0)
    );

    mealy_switch_toggle #(.INIT_ON(1'b1)) u_dut1 (
        .clock  (clk),
        .reset  (rst1),
        .control(ctl1),
        .out    (out1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input int d, input logic e, input string n);
        q_dut.push_back(d);
        q_exp.push_back(e);
        q_name.push_back(n);
        n_push++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops each expectation and compares it with the live output.
    initial begin
        int    d;
        logic  e;
        logic  a;
        string n;
        forever begin
            wait (n_push > n_pop);
            d = q_dut.pop_front();
            e = q_exp.pop_front();
            n = q_name.pop_front();
            n_pop++;
            a = (d == 1) ? out1 : out0;
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s (INIT_ON=%0d): out=%b expected %b at %0t", n, d, a, e, $time);
            end
        end
    end

    initial begin
        rst0 = 1'b0; ctl0 = 1'b0;
        rst1 = 1'b0; ctl1 = 1'b0;

        // Reset hold with the button released, then pressed.
        cyc(10);
        #1 chk(0, 1'b0, "rst_out");
        ctl0 = 1'b1;
        #1 chk(0, 1'b0, "rst_ctl_override");
        ctl0 = 1'b0;
        cyc(1); rst0 = 1'b1;
        #1 chk(0, 1'b0, "rel_out");
        cyc(2);
        #1 chk(0, 1'b0, "idle_out");

        // Long press toggles once; release keeps the light on.
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b1, "press_comb");
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            #1 chk(0, 1'b1, "press_hold");
        end
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b1, "release_on");
        cyc(1);
        #1 chk(0, 1'b1, "on_rel_idle");

        // One-edge press from ON_REL turns the light off.
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b0, "off_press");
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b0, "off_release");
        cyc(1);
        #1 chk(0, 1'b0, "off_rel_idle");

        // Reset in the middle of a press; the held level must not toggle.
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b1, "mp_press");
        cyc(1);
        #1 chk(0, 1'b1, "mp_held");
        #2 rst0 = 1'b0;
        #1 chk(0, 1'b0, "mp_reset");
        cyc(2); rst0 = 1'b1;
        #1 chk(0, 1'b0, "mp_release_held");
        cyc(2);
        #1 chk(0, 1'b0, "mp_no_toggle");
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b0, "mp_drop");
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b1, "mp_repress");
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b1, "mp_rerelease");

        // Back to OFF_REL.
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b0, "back_off_press");
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b0, "back_off_release");

        // 3 ns glitch between edges: visible on out only.
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b1, "glitch_hi");
        #2 ctl0 = 1'b0;
        #1 chk(0, 1'b0, "glitch_lo");
        cyc(2);
        #1 chk(0, 1'b0, "glitch_after");
        cyc(1); ctl0 = 1'b1;
        #1 chk(0, 1'b1, "post_glitch_press");
        cyc(1); ctl0 = 1'b0;
        #1 chk(0, 1'b1, "post_glitch_release");

        // INIT_ON=1 instance.
        ctl1 = 1'b1;
        #1 chk(1, 1'b1, "i1_rst_ctl_override");
        ctl1 = 1'b0;
        #1 chk(1, 1'b1, "i1_rst");
        cyc(1); rst1 = 1'b1;
        #1 chk(1, 1'b1, "i1_rel");
        cyc(2);
        #1 chk(1, 1'b1, "i1_idle");
        cyc(1); ctl1 = 1'b1;
        #1 chk(1, 1'b0, "i1_press1");
        cyc(2);
        #1 chk(1, 1'b0, "i1_held1");
        cyc(1); ctl1 = 1'b0;
        #1 chk(1, 1'b0, "i1_release1");
        cyc(1); ctl1 = 1'b1;
        #1 chk(1, 1'b1, "i1_press2");
        cyc(1); ctl1 = 1'b0;
        #1 chk(1, 1'b1, "i1_release2");
        cyc(1);
        #1 chk(1, 1'b1, "i1_idle2");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 100 && n_pop < n_push; i++) #1;
        if (n_pop < n_push) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", n_push - n_pop);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Watchdog against a stuck stimulus thread.
    initial begin
        #50000;
        $display("FAIL watchdog: time %0t reached, required earlier finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
